// File: rtl/wei_serializer.sv
`default_nettype none
// ============================================================================
// Module   : wei_serializer
// Purpose  : Weight-word serializer. Buffers 16-bit weight words in a small
//            FIFO and shifts each word to the chip over chip_wsclk/chip_wsdi.
//            After WORDS_PER_ROW words it pulses chip_ww to commit the row,
//            then reports the completed row on sta_wei_wr.
// Build option: define WEI_SER_LSB_FIRST_EN to shift bit 0 first. Without it
//            the word goes out MSB first. Timing is the same in both builds.
// Ports    :
//   clk, rst_n      - clock, asynchronous active-low reset
//   loadw_st        - one-cycle session start: flush FIFO and counters, abort
//   data_wei        - 16-bit weight word
//   data_wei_vld    - one-cycle write strobe for data_wei
//   cfg_weight_drv  - chip_ww pulse width minus one, in clk cycles
//   ctrl_force_ww   - debug request for a chip_ww pulse (IDLE, FIFO empty)
//   chip_wsclk      - serial shift clock to the chip
//   chip_wsdi       - serial data to the chip
//   chip_ww         - row write strobe to the chip
//   sta_wei_wr      - one-cycle pulse after each completed row
//   fifo_full       - FIFO holds FIFO_DEPTH words
//   fifo_ovf        - sticky: a word was dropped because the FIFO was full
//   busy            - FSM not idle or FIFO not empty
// Revision : 1.0 - initial release
// ============================================================================
module wei_serializer #(
  parameter int SCLK_HALF     = 2,
  parameter int WORDS_PER_ROW = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loadw_st,
  input  logic [15:0] data_wei,
  input  logic        data_wei_vld,
  input  logic [1:0]  cfg_weight_drv,
  input  logic        ctrl_force_ww,
  output logic        chip_wsclk,
  output logic        chip_wsdi,
  output logic        chip_ww,
  output logic        sta_wei_wr,
  output logic        fifo_full,
  output logic        fifo_ovf,
  output logic        busy
);

  localparam int              c_ptr_w        = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0] c_depth       = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [4:0]      c_sclk_half    = 5'(SCLK_HALF);
  localparam logic [4:0]      c_bit_last_ph  = 5'(2 * SCLK_HALF - 1);
  localparam logic [3:0]      c_words_row    = 4'(WORDS_PER_ROW);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WW    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // FIFO storage and bookkeeping
  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w:0]    r_count;
  logic                r_ovf;

  // Shift datapath
  logic [15:0]         r_shreg;
  logic [3:0]          r_bit_cnt;
  logic [4:0]          r_phase;
  logic [3:0]          r_word_cnt;
  logic [1:0]          r_ww_cnt;
  logic                r_forced;   // current WW was a debug request, not a row

  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_ww_enter;
  logic                w_bit_end;
  logic                w_cur_bit;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == c_depth);
  assign w_bit_end    = (r_phase == c_bit_last_ph);

`ifdef WEI_SER_LSB_FIRST_EN
  assign w_cur_bit = r_shreg[0];
`else
  assign w_cur_bit = r_shreg[15];
`endif

  // A push while full is still accepted when the same cycle pops a word.
  assign w_push = data_wei_vld && !loadw_st && (!w_fifo_full || w_pop);
  assign w_drop = data_wei_vld && !loadw_st && w_fifo_full && !w_pop;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_ww_enter = 1'b0;
    chip_wsclk = 1'b0;
    chip_wsdi  = 1'b0;
    chip_ww    = 1'b0;
    sta_wei_wr = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_next = ST_LOAD;
        end else if (ctrl_force_ww) begin
          w_next     = ST_WW;
          w_ww_enter = 1'b1;
        end
      end
      ST_LOAD: begin
        w_pop  = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Clock low for the first half of each bit, high for the second,
        // so data changes only while the clock is low.
        chip_wsclk = (r_phase >= c_sclk_half);
        chip_wsdi  = w_cur_bit;
        if (w_bit_end && (r_bit_cnt == 4'd15)) begin
          if ((r_word_cnt + 4'd1) == c_words_row) begin
            w_next     = ST_WW;
            w_ww_enter = 1'b1;
          end else if (!w_fifo_empty) begin
            w_next = ST_LOAD;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_WW: begin
        chip_ww = 1'b1;
        if (r_ww_cnt == 2'd0) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        sta_wei_wr = 1'b1;
        w_next     = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Session start aborts everything and silences the chip interface.
    if (loadw_st) begin
      w_next     = ST_IDLE;
      w_pop      = 1'b0;
      w_ww_enter = 1'b0;
      chip_wsclk = 1'b0;
      chip_wsdi  = 1'b0;
      chip_ww    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State register and shift datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_phase    <= '0;
      r_word_cnt <= '0;
      r_ww_cnt   <= '0;
      r_forced   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (loadw_st) begin
        r_bit_cnt  <= '0;
        r_phase    <= '0;
        r_word_cnt <= '0;
        r_forced   <= 1'b0;
      end else begin
        if (w_ww_enter) begin
          r_ww_cnt <= cfg_weight_drv;
          r_forced <= (r_state == ST_IDLE);
        end
        case (r_state)
          ST_LOAD: begin
            r_shreg   <= r_mem[r_rd_ptr];
            r_bit_cnt <= '0;
            r_phase   <= '0;
          end
          ST_SHIFT: begin
            if (w_bit_end) begin
              r_phase   <= '0;
              r_bit_cnt <= r_bit_cnt + 4'd1;
`ifdef WEI_SER_LSB_FIRST_EN
              r_shreg   <= {1'b0, r_shreg[15:1]};
`else
              r_shreg   <= {r_shreg[14:0], 1'b0};
`endif
              if (r_bit_cnt == 4'd15) begin
                r_word_cnt <= r_word_cnt + 4'd1;
              end
            end else begin
              r_phase <= r_phase + 5'd1;
            end
          end
          ST_WW: begin
            if (r_ww_cnt != 2'd0) begin
              r_ww_cnt <= r_ww_cnt - 2'd1;
            end
          end
          ST_DONE: begin
            // A debug pulse leaves a partially filled row intact.
            if (!r_forced) begin
              r_word_cnt <= '0;
            end
            r_forced <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_wei;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (loadw_st) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign fifo_full = w_fifo_full;
  assign fifo_ovf  = r_ovf;
  assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_wei_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wei_serializer
// Purpose  : Self-checking bench for wei_serializer. Words written into the
//            DUT are queued as expectations; a monitor rebuilds each serial
//            word from chip_wsclk/chip_wsdi and compares it against the queue,
//            and also tracks chip_ww / sta_wei_wr pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wei_serializer;

  localparam int SCLK_HALF     = 2;
  localparam int WORDS_PER_ROW = 4;
  localparam int FIFO_DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        loadw_st = 1'b0;
  logic [15:0] data_wei = 16'h0000;
  logic        data_wei_vld = 1'b0;
  logic [1:0]  cfg_weight_drv = 2'd2;
  logic        ctrl_force_ww = 1'b0;
  logic        chip_wsclk;
  logic        chip_wsdi;
  logic        chip_ww;
  logic        sta_wei_wr;
  logic        fifo_full;
  logic        fifo_ovf;
  logic        busy;

  wei_serializer #(
    .SCLK_HALF     (SCLK_HALF),
    .WORDS_PER_ROW (WORDS_PER_ROW),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .loadw_st       (loadw_st),
    .data_wei       (data_wei),
    .data_wei_vld   (data_wei_vld),
    .cfg_weight_drv (cfg_weight_drv),
    .ctrl_force_ww  (ctrl_force_ww),
    .chip_wsclk     (chip_wsclk),
    .chip_wsdi      (chip_wsdi),
    .chip_ww        (chip_ww),
    .sta_wei_wr     (sta_wei_wr),
    .fifo_full      (fifo_full),
    .fifo_ovf       (fifo_ovf),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q [$];

  // monitor state
  int          bit_n = 0;
  int          gap = 0;
  int          words_since_ww = 0;
  int          ww_run = 0;
  int          ww_pulses = 0;
  int          sta_cnt = 0;
  int          exp_ww_w = 3;
  logic        exp_forced = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_wsdi = 1'b0;
  logic        prev_ww = 1'b0;
  logic [15:0] mon_sh = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Word as rebuilt by the monitor (first serial bit lands in bit 15).
  function automatic logic [15:0] ord(input logic [15:0] w);
    logic [15:0] r;
`ifdef WEI_SER_LSB_FIRST_EN
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
`else
    r = w;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || loadw_st) begin
      bit_n          = 0;
      gap            = 0;
      ww_run         = 0;
      words_since_ww = 0;
      prev_sclk      = 1'b0;
      prev_ww        = 1'b0;
      mon_sh         = 16'h0000;
    end else begin
      if (chip_wsclk && prev_sclk) begin
        check("wsdi_stable_hi", 32'(chip_wsdi), 32'(prev_wsdi));
      end
      if (chip_wsclk && !prev_sclk) begin
        if (bit_n > 0) check("sclk_period", gap, 2 * SCLK_HALF);
        mon_sh = {mon_sh[14:0], chip_wsdi};
        bit_n++;
        gap = 0;
        if (bit_n == 16) begin
          if (exp_q.size() == 0) check("word_q_size", exp_q.size(), 1);
          else check("word", 32'(mon_sh), 32'(ord(exp_q.pop_front())));
          bit_n = 0;
          words_since_ww++;
        end
      end
      gap++;
      if (chip_ww && !prev_ww) begin
        ww_pulses++;
        check("ww_bitpos", bit_n, 0);
        if (!exp_forced) begin
          check("row_words", words_since_ww, WORDS_PER_ROW);
          words_since_ww = 0;
        end
      end
      if (chip_ww) begin
        ww_run++;
      end else if (prev_ww) begin
        check("ww_width", ww_run, exp_ww_w);
        ww_run = 0;
      end
      if (sta_wei_wr) begin
        sta_cnt++;
        check("sta_after_ww", 32'(prev_ww), 1);
      end
      prev_sclk = chip_wsclk;
      prev_wsdi = chip_wsdi;
      prev_ww   = chip_ww;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    data_wei     = d;
    data_wei_vld = 1'b1;
    exp_q.push_back(d);
    tick;
    data_wei_vld = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick;
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 32'({chip_wsclk, chip_wsdi, chip_ww, sta_wei_wr, fifo_full, fifo_ovf, busy}), 0);
    rst_n = 1'b1;
    tick;

    // ---------------- latency and serial data of 16'hA5C3
    exp_q.push_back(16'hA5C3);
    data_wei     = 16'hA5C3;
    data_wei_vld = 1'b1;
    tick;                                   // after edge N
    data_wei_vld = 1'b0;
    check("lat_busy_n", 32'(busy), 1);
    tick;                                   // after edge N+1 (LOAD)
    check("lat_sclk_n1", 32'(chip_wsclk), 0);
    tick;                                   // after edge N+2 (first bit)
    check("lat_first_bit", 32'(chip_wsdi), 1);
    check("lat_sclk_n2", 32'(chip_wsclk), 0);
    tick;
    check("lat_sclk_n3", 32'(chip_wsclk), 0);
    tick;
    check("lat_sclk_n4", 32'(chip_wsclk), 1);

    // ---------------- complete the row: 3 more words, cfg_weight_drv=2
    cfg_weight_drv = 2'd2;
    exp_ww_w       = 3;
    push(16'h1234);
    push(16'h8001);
    push(16'h7FFE);
    wait_idle(2000);
    check("row_q", exp_q.size(), 0);
    check("row_ww_cnt", ww_pulses, 1);
    check("row_sta_cnt", sta_cnt, 1);

    // ---------------- overflow: 6 consecutive writes, 6th dropped
    for (int i = 0; i < 6; i++) begin
      data_wei     = 16'hF0F0 ^ 16'(i * 16'h1111);
      data_wei_vld = 1'b1;
      if (i < 5) exp_q.push_back(data_wei);
      tick;
      if (i == 4) begin
        check("ovf_full4", 32'(fifo_full), 1);
        check("ovf_pre", 32'(fifo_ovf), 0);
      end
      if (i == 5) begin
        check("ovf_full5", 32'(fifo_full), 1);
        check("ovf_set", 32'(fifo_ovf), 1);
      end
    end
    data_wei_vld = 1'b0;
    wait_idle(3000);
    check("ovf_q", exp_q.size(), 0);
    check("ovf_sticky", 32'(fifo_ovf), 1);
    check("ovf_ww_cnt", ww_pulses, 2);
    loadw_st = 1'b1;
    tick;
    loadw_st = 1'b0;
    check("ovf_clr", 32'(fifo_ovf), 0);
    check("ovf_clr_busy", 32'(busy), 0);

    // ---------------- abort during bit 7 of the second word
    push(16'h0F0F);
    push(16'hC33C);
    n = 0;
    while (!(words_since_ww == 1 && bit_n == 7) && n < 500) begin
      tick;
      n++;
    end
    check("abort_reach", 32'(n < 500), 1);
    loadw_st     = 1'b1;
    data_wei     = 16'hDEAD;
    data_wei_vld = 1'b1;
    #1;
    check("abort_sclk_now", 32'(chip_wsclk), 0);
    check("abort_wsdi_now", 32'(chip_wsdi), 0);
    tick;
    loadw_st     = 1'b0;
    data_wei_vld = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 0);
    check("abort_sclk", 32'(chip_wsclk), 0);
    check("abort_ovf", 32'(fifo_ovf), 0);
    push(16'hAAAA);
    push(16'h5555);
    push(16'h0180);
    push(16'hFE7F);
    wait_idle(3000);
    check("abort_q", exp_q.size(), 0);
    check("abort_ww_cnt", ww_pulses, 3);
    check("abort_sta_cnt", sta_cnt, 3);

    // ---------------- forced write with a partial row pending
    push(16'h5AA5);
    wait_idle(1000);
    cfg_weight_drv = 2'd0;
    exp_ww_w       = 1;
    exp_forced     = 1'b1;
    ctrl_force_ww  = 1'b1;
    tick;
    ctrl_force_ww  = 1'b0;
    wait_idle(50);
    exp_forced     = 1'b0;
    check("force_ww_cnt", ww_pulses, 4);
    check("force_sta_cnt", sta_cnt, 4);
    cfg_weight_drv = 2'd2;
    exp_ww_w       = 3;
    push(16'h0001);
    push(16'h8000);
    push(16'h00FF);
    ctrl_force_ww  = 1'b1;                  // not idle: must be ignored
    tick;
    ctrl_force_ww  = 1'b0;
    wait_idle(3000);
    check("force_q", exp_q.size(), 0);
    check("force_row_ww_cnt", ww_pulses, 5);
    check("force_row_sta_cnt", sta_cnt, 5);

    // ---------------- reset asserted in the middle of WW
    cfg_weight_drv = 2'd3;
    exp_ww_w       = 4;
    push(16'h1357);
    push(16'h2468);
    push(16'hBEEF);
    push(16'hCAFE);
    n = 0;
    while (!chip_ww && n < 2000) begin
      tick;
      n++;
    end
    check("rst_ww_reach", 32'(chip_ww), 1);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_ww", 32'(chip_ww), 0);
    check("rst_async_outs", 32'({chip_wsclk, chip_wsdi, chip_ww, sta_wei_wr, fifo_full, fifo_ovf, busy}), 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_busy", 32'(busy), 0);
    push(16'h9669);
    wait_idle(1000);
    check("rst_q", exp_q.size(), 0);
    check("rst_ww_cnt", ww_pulses, 6);
    check("rst_sta_cnt", sta_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
